// File: rtl/marquee_ring_buffer.sv
// Circular symbol buffer for the seven-segment marquee: a register ring plus a
// head pointer, rotated by a prescaler or by single steps, with a VISIBLE-wide window.
module marquee_ring_buffer #(
   parameter int                DATA_W   = 5,
   parameter int                DEPTH    = 16,
   parameter int                VISIBLE  = 9,
   parameter logic [DATA_W-1:0] BLANK    = 5'h10,
   parameter int                TICK_DIV = 4
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        clear,
   input  logic                        wr_en,
   input  logic [$clog2(DEPTH)-1:0]    wr_pos,
   input  logic [DATA_W-1:0]           wr_data,
   input  logic                        run,
   input  logic                        step,
   input  logic                        direction,
   output logic [VISIBLE*DATA_W-1:0]   win,
   output logic [$clog2(DEPTH)-1:0]    head,
   output logic                        wrap
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [AW-1:0] HEAD_MAX = AW'(DEPTH - 1);
   localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);
   localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);

   logic [DATA_W-1:0] ring_reg [DEPTH];
   logic [AW-1:0]     head_reg, head_next;
   logic [PW-1:0]     pre_reg, pre_next;
   logic              wrap_reg;
   logic              step_now;
   logic [AW:0]       wr_sum;
   logic [AW-1:0]     wr_addr;
   logic              wr_ok;

   // Prescaler sits at 0 while stopped, so the first run step lands TICK_DIV cycles in.
   always_comb begin
      step_now  = run ? (pre_reg == PRE_MAX) : step;
      pre_next  = '0;
      if (run && (pre_reg != PRE_MAX))
         pre_next = pre_reg + 1'b1;
      head_next = head_reg;
      if (step_now) begin
         if (direction)
            head_next = (head_reg == '0) ? HEAD_MAX : head_reg - 1'b1;
         else
            head_next = (head_reg == HEAD_MAX) ? '0 : head_reg + 1'b1;
      end
      wr_sum  = {1'b0, head_reg} + {1'b0, wr_pos};
      wr_addr = (wr_sum >= DEPTH_W) ? AW'(wr_sum - DEPTH_W) : wr_sum[AW-1:0];
      wr_ok   = wr_en && (32'(wr_pos) < DEPTH);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            ring_reg[i] <= BLANK;
         head_reg <= '0;
         pre_reg  <= '0;
         wrap_reg <= 1'b0;
      end else if (clear) begin
         for (int i = 0; i < DEPTH; i++)
            ring_reg[i] <= BLANK;
         head_reg <= '0;
         pre_reg  <= '0;
         wrap_reg <= 1'b0;
      end else begin
         // Write address uses the pre-step head; the symbol then rides the rotation.
         if (wr_ok)
            ring_reg[wr_addr] <= wr_data;
         head_reg <= head_next;
         pre_reg  <= pre_next;
         wrap_reg <= step_now && (head_next == '0);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < VISIBLE; gi++) begin : g_win
         logic [AW:0]   rd_sum;
         logic [AW-1:0] rd_idx;
         assign rd_sum = {1'b0, head_reg} + (AW + 1)'(gi);
         assign rd_idx = (rd_sum >= DEPTH_W) ? AW'(rd_sum - DEPTH_W) : rd_sum[AW-1:0];
         assign win[gi*DATA_W +: DATA_W] = ring_reg[rd_idx];
      end
   endgenerate

   assign head = head_reg;
   assign wrap = wrap_reg;

endmodule

// File: tb/tb_marquee_ring_buffer.sv
// Bench for marquee_ring_buffer: directed scenarios plus randomized traffic,
// all checked against a modular-arithmetic model of ring, head and prescaler.
module tb_marquee_ring_buffer;

   localparam int                DATA_W   = 5;
   localparam int                DEPTH    = 16;
   localparam int                VISIBLE  = 9;
   localparam logic [DATA_W-1:0] BLANK    = 5'h10;
   localparam int                TICK_DIV = 4;
   localparam int                AW       = $clog2(DEPTH);

   logic                      clock = 1'b0;
   logic                      reset, clear, wr_en, run, step, direction;
   logic [AW-1:0]             wr_pos;
   logic [DATA_W-1:0]         wr_data;
   logic [VISIBLE*DATA_W-1:0] win;
   logic [AW-1:0]             head;
   logic                      wrap;

   int total = 0;
   int bad   = 0;

   logic [DATA_W-1:0] m_ring [DEPTH];
   int                m_head, m_pre;
   logic              m_wrap;

   marquee_ring_buffer #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .VISIBLE(VISIBLE),
      .BLANK(BLANK), .TICK_DIV(TICK_DIV)
   ) dut (
      .clock(clock), .reset(reset), .clear(clear), .wr_en(wr_en),
      .wr_pos(wr_pos), .wr_data(wr_data), .run(run), .step(step),
      .direction(direction), .win(win), .head(head), .wrap(wrap)
   );

   always #5 clock = ~clock;

   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) m_ring[i] = BLANK;
      m_head = 0;
      m_pre  = 0;
      m_wrap = 1'b0;
   endfunction

   // One clock edge of behaviour, evaluated from the current input values.
   function automatic void model_edge();
      bit do_step;
      if (clear) begin
         model_reset();
         return;
      end
      do_step = run ? (m_pre == TICK_DIV - 1) : step;
      m_pre   = run ? (m_pre + 1) % TICK_DIV : 0;
      if (wr_en && int'(wr_pos) < DEPTH)
         m_ring[(m_head + int'(wr_pos)) % DEPTH] = wr_data;
      if (do_step)
         m_head = direction ? (m_head + DEPTH - 1) % DEPTH : (m_head + 1) % DEPTH;
      m_wrap = do_step && (m_head == 0);
   endfunction

   function automatic logic [VISIBLE*DATA_W-1:0] model_win();
      logic [VISIBLE*DATA_W-1:0] w;
      for (int i = 0; i < VISIBLE; i++)
         w[i*DATA_W +: DATA_W] = m_ring[(m_head + i) % DEPTH];
      return w;
   endfunction

   task automatic idle_inputs();
      clear = 0; wr_en = 0; wr_pos = '0; wr_data = '0;
      run = 0; step = 0; direction = 0;
   endtask

   task automatic tick();
      @(posedge clock);
      if (!reset) model_edge();
      @(negedge clock);
   endtask

   task automatic apply_reset();
      idle_inputs();
      reset = 1;
      model_reset();
      @(negedge clock);
      @(negedge clock);
      reset = 0;
   endtask

   task automatic load_digits();
      for (int k = 0; k < VISIBLE; k++) begin
         wr_en = 1; wr_pos = AW'(k); wr_data = DATA_W'(k);
         tick();
      end
      wr_en = 0;
   endtask

   task automatic test_reset();
      logic [VISIBLE*DATA_W-1:0] blank_win;
      for (int i = 0; i < VISIBLE; i++) blank_win[i*DATA_W +: DATA_W] = BLANK;
      idle_inputs();
      reset = 1;
      model_reset();
      #1;
      total++;
      if (win !== blank_win || head !== '0 || wrap !== 1'b0) begin
         bad++;
         $display("FAIL reset_state win=%h head=%0d wrap=%b required win=%h head=0 wrap=0", win, head, wrap, blank_win);
      end
      @(negedge clock);
      reset = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         total++;
         if (win !== blank_win || head !== '0 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold c=%0d win=%h head=%0d wrap=%b required win=%h head=0 wrap=0", c, win, head, wrap, blank_win);
         end
      end
      $display("test_reset: done");
   endtask

   task automatic test_write();
      logic [VISIBLE*DATA_W-1:0] exp;
      for (int k = 0; k < VISIBLE; k++) exp[k*DATA_W +: DATA_W] = DATA_W'(k);
      apply_reset();
      load_digits();
      total++;
      if (win !== exp || head !== '0) begin
         bad++;
         $display("FAIL write_digits win=%h head=%0d required win=%h head=0", win, head, exp);
      end
      $display("test_write: win=%h", win);
   endtask

   task automatic test_step();
      int wraps = 0;
      direction = 0; step = 1;
      tick();
      step = 0;
      total++;
      if (head !== AW'(1) || win[DATA_W-1:0] !== DATA_W'(1) || win !== model_win()) begin
         bad++;
         $display("FAIL single_step head=%0d pos0=%h required head=1 pos0=1", head, win[DATA_W-1:0]);
      end
      for (int p = 1; p <= DEPTH; p++) begin
         step = 1;
         tick();
         if (wrap) wraps++;
         total++;
         if (head !== AW'((1 + p) % DEPTH) || wrap !== (p == DEPTH - 1) || win !== model_win()) begin
            bad++;
            $display("FAIL step_pulse p=%0d head=%0d wrap=%b required head=%0d wrap=%b", p, head, wrap, (1 + p) % DEPTH, p == DEPTH - 1);
         end
      end
      step = 0;
      total++;
      if (wraps != 1 || head !== AW'(1)) begin
         bad++;
         $display("FAIL step_wrap_count wraps=%0d head=%0d required wraps=1 head=1", wraps, head);
      end
      $display("test_step: head=%0d wraps=%0d", head, wraps);
   endtask

   task automatic test_run();
      int wraps = 0;
      apply_reset();
      load_digits();
      run = 1; direction = 1;
      for (int c = 1; c <= TICK_DIV; c++) begin
         tick();
         total++;
         if (head !== ((c < TICK_DIV) ? AW'(0) : AW'(DEPTH - 1))) begin
            bad++;
            $display("FAIL run_first_step c=%0d head=%0d required %0d", c, head, (c < TICK_DIV) ? 0 : DEPTH - 1);
         end
      end
      total++;
      if (win[DATA_W-1:0] !== BLANK) begin
         bad++;
         $display("FAIL run_pos0 pos0=%h required %h", win[DATA_W-1:0], BLANK);
      end
      for (int c = 0; c < DEPTH * TICK_DIV; c++) begin
         tick();
         if (wrap) wraps++;
         total++;
         if (win !== model_win() || head !== AW'(m_head) || wrap !== m_wrap) begin
            bad++;
            $display("FAIL run_track c=%0d head=%0d wrap=%b required head=%0d wrap=%b", c, head, wrap, m_head, m_wrap);
         end
      end
      run = 0;
      total++;
      if (wraps != 1 || head !== AW'(DEPTH - 1)) begin
         bad++;
         $display("FAIL run_wrap_count wraps=%0d head=%0d required wraps=1 head=%0d", wraps, head, DEPTH - 1);
      end
      $display("test_run: head=%0d wraps=%0d", head, wraps);
   endtask

   task automatic test_write_step();
      apply_reset();
      load_digits();
      direction = 0; step = 1;
      repeat (3) tick();
      wr_en = 1; wr_pos = '0; wr_data = 5'h07; step = 1; direction = 0;
      tick();
      wr_en = 0; step = 0;
      total++;
      if (head !== AW'(4) || win[DATA_W-1:0] !== DATA_W'(4) || win !== model_win()) begin
         bad++;
         $display("FAIL write_step head=%0d pos0=%h win=%h required head=4 pos0=04 win=%h", head, win[DATA_W-1:0], win, model_win());
      end
      direction = 1; step = 1;
      tick();
      step = 0;
      total++;
      if (head !== AW'(3) || win[DATA_W-1:0] !== 5'h07) begin
         bad++;
         $display("FAIL write_step_back head=%0d pos0=%h required head=3 pos0=07", head, win[DATA_W-1:0]);
      end
      $display("test_write_step: head=%0d pos0=%h", head, win[DATA_W-1:0]);
   endtask

   task automatic test_clear();
      clear = 1; wr_en = 1; wr_pos = AW'(2); wr_data = 5'h03; step = 1; direction = 0;
      tick();
      idle_inputs();
      total++;
      if (win !== model_win() || head !== '0 || wrap !== 1'b0 || win[2*DATA_W +: DATA_W] !== BLANK) begin
         bad++;
         $display("FAIL clear_priority win=%h head=%0d wrap=%b required win=%h head=0 wrap=0", win, head, wrap, model_win());
      end
      load_digits();
      run = 1; direction = 0;
      repeat (6) tick();
      #2;
      reset = 1;
      model_reset();
      #1;
      total++;
      if (win !== model_win() || head !== '0 || wrap !== 1'b0) begin
         bad++;
         $display("FAIL reset_midrun win=%h head=%0d wrap=%b required win=%h head=0 wrap=0", win, head, wrap, model_win());
      end
      @(negedge clock);
      reset = 0;
      idle_inputs();
      $display("test_clear: head=%0d", head);
   endtask

   task automatic test_random();
      int errs = 0;
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 15) == 0) run = ~run;
         step      = ($urandom_range(0, 2) == 0);
         direction = ($urandom_range(0, 5) == 0) ? ~direction : direction;
         wr_en     = ($urandom_range(0, 1) == 1);
         wr_pos    = AW'($urandom_range(0, DEPTH - 1));
         wr_data   = DATA_W'($urandom);
         clear     = ($urandom_range(0, 40) == 0);
         tick();
         total++;
         if (win !== model_win() || head !== AW'(m_head) || wrap !== m_wrap) begin
            bad++;
            errs++;
            $display("FAIL random c=%0d win=%h head=%0d wrap=%b required win=%h head=%0d wrap=%b", c, win, head, wrap, model_win(), m_head, m_wrap);
         end
      end
      idle_inputs();
      $display("test_random: 400 cycles, errors=%0d", errs);
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      model_reset();
      test_reset();
      test_write();
      test_step();
      test_run();
      test_write_step();
      test_clear();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
